// File: rtl/filter_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the
// time-multiplexed 31-tap symmetric FIR.
package filter_pkg;

  localparam int DW    = 10;
  localparam int CW    = 16;
  localparam int AW    = 32;
  localparam int FRAC  = 15;
  localparam int NTAPS = 31;
  localparam int NFOLD = 16;
  localparam int KW    = 4;
  localparam int PW    = CW + DW + 2;

  localparam logic signed [AW-1:0] ROUND_HALF = AW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] OUT_MAX    = AW'((1 << DW) - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Folded Q1.15 coefficients; index 15 is the centre tap.
  function automatic logic signed [CW-1:0] coef(input logic [KW-1:0] k);
    case (k)
      4'd0:    coef = -16'sd66;
      4'd1:    coef = -16'sd7;
      4'd2:    coef = 16'sd56;
      4'd3:    coef = 16'sd33;
      4'd4:    coef = -16'sd174;
      4'd5:    coef = -16'sd423;
      4'd6:    coef = -16'sd338;
      4'd7:    coef = 16'sd216;
      4'd8:    coef = 16'sd675;
      4'd9:    coef = 16'sd144;
      4'd10:   coef = -16'sd1386;
      4'd11:   coef = -16'sd2376;
      4'd12:   coef = -16'sd793;
      4'd13:   coef = 16'sd3732;
      4'd14:   coef = 16'sd8867;
      default: coef = 16'sd11128;
    endcase
  endfunction

  function automatic logic [DW-1:0] saturate(input logic signed [AW-1:0] x);
    if (x < 0) begin
      saturate = '0;
    end else if (x > OUT_MAX) begin
      saturate = '1;
    end else begin
      saturate = x[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// 31-entry sample shift register with two combinational read ports that
// return the symmetric tap pair v[k] and v[30-k].
module sample_delay_line
  import filter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_shift,
  input  logic [DW-1:0] i_sample,
  input  logic [KW-1:0] i_k,
  output logic [DW-1:0] o_tapLo,
  output logic [DW-1:0] o_tapHi
);

  logic [DW-1:0] r_line [NTAPS];
  logic [4:0]    w_loIdx;
  logic [4:0]    w_hiIdx;

  // Newest sample enters at the top; the oldest falls off index 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_line[i] <= '0;
      end
    end else if (i_shift) begin
      for (int i = 0; i < NTAPS - 1; i++) begin
        r_line[i] <= r_line[i+1];
      end
      r_line[NTAPS-1] <= i_sample;
    end
  end

  assign w_loIdx = {1'b0, i_k};
  assign w_hiIdx = 5'(NTAPS - 1) - w_loIdx;
  assign o_tapLo = r_line[w_loIdx];
  assign o_tapHi = r_line[w_hiIdx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one multiplier/accumulator over the 16 folded taps of the
// symmetric FIR, then rounds, saturates and presents the filtered sample.
module fir_mac_sequencer
  import filter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] filtered,
  output logic          overrun
);

  state_t r_state;
  state_t w_nextState;

  logic [KW-1:0]        r_k;
  logic signed [AW-1:0] r_acc;
  logic [4:0]           r_prime;
  logic [DW-1:0]        r_result;
  logic                 r_fire;
  logic                 r_fireValid;
  logic                 r_outValid;
  logic [DW-1:0]        r_filtered;
  logic                 r_overrun;

  logic                 w_accept;
  logic                 w_lastTap;
  logic [DW-1:0]        w_tapLo;
  logic [DW-1:0]        w_tapHi;
  logic [DW:0]          w_pairSum;
  logic signed [DW+1:0] w_pair;
  logic signed [CW-1:0] w_coef;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_rounded;

  assign w_accept  = (r_state == IDLE) && sample_valid;
  assign w_lastTap = (r_k == KW'(NFOLD - 1));

  sample_delay_line u_delayLine (
    .clk      (clk),
    .reset    (reset),
    .i_shift  (w_accept),
    .i_sample (sample),
    .i_k      (r_k),
    .o_tapLo  (w_tapLo),
    .o_tapHi  (w_tapHi)
  );

  // The centre tap has no partner, so its pair contributes only v[15].
  assign w_pairSum = {1'b0, w_tapLo} + (w_lastTap ? '0 : {1'b0, w_tapHi});
  assign w_pair    = signed'({1'b0, w_pairSum});
  assign w_coef    = coef(r_k);
  assign w_prod    = w_coef * w_pair;
  assign w_rounded = (r_acc + ROUND_HALF) >>> FRAC;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (sample_valid) w_nextState = MAC;
      MAC:     if (w_lastTap) w_nextState = OUT;
      OUT:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // OUT captures the saturated result; it is published one edge later so
  // the output lands 18 edges after acceptance while IDLE is already free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k         <= '0;
      r_acc       <= '0;
      r_prime     <= '0;
      r_result    <= '0;
      r_fire      <= 1'b0;
      r_fireValid <= 1'b0;
      r_outValid  <= 1'b0;
      r_filtered  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_fire     <= 1'b0;
      r_outValid <= 1'b0;
      if (sample_valid && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_acc <= '0;
            r_k   <= '0;
            if (r_prime != 5'(NTAPS)) begin
              r_prime <= r_prime + 5'd1;
            end
          end
        end
        MAC: begin
          r_acc <= r_acc + AW'(w_prod);
          r_k   <= r_k + KW'(1);
        end
        OUT: begin
          r_result    <= saturate(w_rounded);
          r_fireValid <= (r_prime == 5'(NTAPS));
          r_fire      <= 1'b1;
        end
        default: begin
          r_k <= '0;
        end
      endcase
      if (r_fire) begin
        r_filtered <= r_result;
        r_outValid <= r_fireValid;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign out_valid = r_outValid;
  assign filtered  = r_filtered;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: directed and random samples scored against an
// unfolded 31-tap convolution model with priming and overrun tracking.
module tb_fir_mac_sequencer;

  localparam int NT = 31;

  logic       clk;
  logic       reset;
  logic       sampleValid;
  logic [9:0] sampleIn;
  logic       busy;
  logic       outValid;
  logic [9:0] filtered;
  logic       overrun;

  int checkCount = 0;
  int errorCount = 0;

  int coefA[16] = '{-66, -7, 56, 33, -174, -423, -338, 216, 675, 144,
                    -1386, -2376, -793, 3732, 8867, 11128};
  int hist[NT];
  int primeCount;
  bit expOverrun;
  bit havePending;
  bit pendValid;
  int pendOut;
  string phase;
  bit sawValid;
  int dropVal;

  fir_mac_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sampleValid),
    .sample       (sampleIn),
    .busy         (busy),
    .out_valid    (outValid),
    .filtered     (filtered),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int modelFilter();
    longint acc = 0;
    longint rounded;
    for (int i = 0; i < NT; i++) begin
      int tap = (i <= 15) ? i : (NT - 1 - i);
      acc += longint'(coefA[tap]) * longint'(hist[i]);
    end
    rounded = (acc + 64'sd16384) >>> 15;
    if (rounded < 0) return 0;
    if (rounded > 1023) return 1023;
    return int'(rounded);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NT; i++) hist[i] = 0;
    primeCount  = 0;
    expOverrun  = 1'b0;
    havePending = 1'b0;
    pendValid   = 1'b0;
    pendOut     = 0;
  endtask

  task automatic modelAccept(input int v);
    for (int i = 0; i < NT - 1; i++) hist[i] = hist[i+1];
    hist[NT-1] = v;
    if (primeCount < NT) primeCount++;
    pendOut   = modelFilter();
    pendValid = (primeCount == NT);
  endtask

  task automatic checkPending();
    checkOutput({phase, "_out_valid"}, 32'(outValid), 32'(pendValid));
    checkOutput({phase, "_filtered"}, 32'(filtered), 32'(pendOut));
    checkOutput({phase, "_overrun"}, 32'(overrun), 32'(expOverrun));
  endtask

  // Drives one sample (called #1 after an edge); returns #1 after edge N+17
  // so a follow-up call is accepted exactly 18 edges later.
  task automatic applyStimulus(input int v);
    sampleValid = 1'b1;
    sampleIn    = 10'(v);
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    if (havePending) begin
      checkPending();
      havePending = 1'b0;
    end
    modelAccept(v);
    checkOutput({phase, "_busy"}, 32'(busy), 32'd1);
    repeat (17) @(posedge clk);
    #1;
    checkOutput({phase, "_early_valid"}, 32'(outValid), 32'd0);
    havePending = 1'b1;
  endtask

  task automatic flushPending();
    if (havePending) begin
      @(posedge clk);
      #1;
      checkPending();
      havePending = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({phase, "_pulse_width"}, 32'(outValid), 32'd0);
    end
  endtask

  initial begin
    modelReset();
    reset       = 1'b0;
    sampleValid = 1'b0;
    sampleIn    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_filtered", 32'(filtered), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);

    $display("[TB] priming with zeros");
    phase = "prime";
    for (int i = 0; i < NT; i++) applyStimulus(0);
    flushPending();

    $display("[TB] impulse response");
    phase = "impulse";
    applyStimulus(1023);
    for (int i = 0; i < 15; i++) applyStimulus(0);
    flushPending();
    checkOutput("impulse_centre", 32'(filtered), 32'd347);
    for (int i = 0; i < 15; i++) applyStimulus(0);
    flushPending();

    $display("[TB] constant full scale");
    phase = "dc";
    for (int i = 0; i < 40; i++) applyStimulus(1023);
    flushPending();
    checkOutput("dc_steady", 32'(filtered), 32'd857);

    $display("[TB] overrun while busy");
    phase = "overrun";
    sampleValid = 1'b1;
    sampleIn    = 10'd500;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    modelAccept(500);
    repeat (4) @(posedge clk);
    #1;
    dropVal     = int'($urandom_range(0, 1023));
    sampleValid = 1'b1;
    sampleIn    = 10'(dropVal);
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    expOverrun  = 1'b1;
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    checkOutput("overrun_busy", 32'(busy), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("overrun_early_valid", 32'(outValid), 32'd0);
    havePending = 1'b1;
    flushPending();

    $display("[TB] back-to-back random samples");
    phase = "random";
    for (int i = 0; i < 100; i++) applyStimulus(int'($urandom_range(0, 1023)));
    flushPending();

    $display("[TB] reset during MAC");
    phase = "abort";
    sampleValid = 1'b1;
    sampleIn    = 10'd777;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_out_valid", 32'(outValid), 32'd0);
    checkOutput("abort_filtered", 32'(filtered), 32'd0);
    checkOutput("abort_overrun", 32'(overrun), 32'd0);
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(sawValid), 32'd0);

    phase = "reprime";
    for (int i = 0; i < NT; i++) applyStimulus(int'($urandom_range(0, 1023)));
    flushPending();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
